// File: rtl/twiddle_controller.sv
// Rotary/pushbutton mode controller: SELECT mode steps the channel index, EDIT mode steps the
// selected setting register; short press toggles mode, long press clears, idle EDIT times out.
module twiddle_controller #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LONG_CYCLES = 8_000_000,
  parameter int unsigned IDLE_CYCLES = 160_000_000,
  localparam int unsigned SW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step_up,
  input  logic                      step_down,
  input  logic                      button,
  output logic [SW-1:0]             sel,
  output logic                      editing,
  output logic [CHANNELS*WIDTH-1:0] values,
  output logic                      changed
);

  localparam int unsigned HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int unsigned IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [HW-1:0] HoldLast = HW'(LONG_CYCLES - 1);
  localparam logic [IW-1:0] IdleLast = IW'(IDLE_CYCLES - 1);
  localparam logic [SW-1:0] SelLast  = SW'(CHANNELS - 1);
  localparam logic [WIDTH-1:0] ValMax = {WIDTH{1'b1}};

  typedef enum logic [0:0] {StSelect, StEdit} mode_e;

  mode_e            mode_q, mode_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0] val_q [CHANNELS];
  logic [WIDTH-1:0] val_d [CHANNELS];
  logic             changed_q, changed_d;
  logic             btn_prev_q;
  logic             long_fired_q, long_fired_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [IW-1:0]    idle_q, idle_d;

  logic press, release_ev, held, step_ok, long_fire, short_rel, timeout;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= StSelect;
      sel_q        <= '0;
      changed_q    <= 1'b0;
      btn_prev_q   <= 1'b1;
      long_fired_q <= 1'b0;
      hold_q       <= '0;
      idle_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) val_q[i] <= '0;
    end else begin
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      changed_q    <= changed_d;
      btn_prev_q   <= button;
      long_fired_q <= long_fired_d;
      hold_q       <= hold_d;
      idle_q       <= idle_d;
      val_q        <= val_d;
    end
  end

  // Next-state logic
  always_comb begin
    press      = btn_prev_q & ~button;
    release_ev = ~btn_prev_q & button;
    held       = ~button;
    step_ok    = button & (step_up ^ step_down);

    hold_d = hold_q;
    if (press) begin
      hold_d = '0;
    end else if (held && (hold_q != HoldLast)) begin
      hold_d = hold_q + 1'b1;
    end
    long_fire = held & ~long_fired_q & (hold_d == HoldLast);
    short_rel = release_ev & ~long_fired_q;

    long_fired_d = long_fired_q;
    if (long_fire) begin
      long_fired_d = 1'b1;
    end else if (release_ev) begin
      long_fired_d = 1'b0;
    end

    // Any activity in the timeout cycle restarts the idle count instead of exiting EDIT.
    timeout = (mode_q == StEdit) & button & ~release_ev & ~step_ok & (idle_q == IdleLast);

    mode_d = mode_q;
    if (short_rel) begin
      mode_d = (mode_q == StEdit) ? StSelect : StEdit;
    end else if (timeout) begin
      mode_d = StSelect;
    end

    idle_d = idle_q + 1'b1;
    if ((mode_q != StEdit) || held || release_ev || step_ok || timeout) begin
      idle_d = '0;
    end

    sel_d = sel_q;
    val_d = val_q;
    if (step_ok) begin
      if (mode_q == StSelect) begin
        if (step_up) begin
          sel_d = (sel_q == SelLast) ? '0 : sel_q + 1'b1;
        end else begin
          sel_d = (sel_q == '0) ? SelLast : sel_q - 1'b1;
        end
      end else if (step_up) begin
        if (val_q[sel_q] != ValMax) val_d[sel_q] = val_q[sel_q] + 1'b1;
      end else begin
        if (val_q[sel_q] != '0) val_d[sel_q] = val_q[sel_q] - 1'b1;
      end
    end
    if (long_fire) begin
      if (mode_q == StEdit) begin
        val_d[sel_q] = '0;
      end else begin
        for (int i = 0; i < CHANNELS; i++) val_d[i] = '0;
      end
    end

    changed_d = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (val_d[i] != val_q[i]) changed_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    sel     = sel_q;
    editing = (mode_q == StEdit);
    changed = changed_q;
    for (int i = 0; i < CHANNELS; i++) values[i*WIDTH +: WIDTH] = val_q[i];
  end

endmodule

// File: tb/tb_twiddle_controller.sv
// Bench for twiddle_controller: scripted scenarios with literal expectations, then randomized
// detent/button traffic checked every cycle against a count-based behavioural model.
module tb_twiddle_controller;
  localparam int CH = 4;
  localparam int W = 8;
  localparam int LONG = 8;
  localparam int IDLE = 32;
  localparam int VMAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_up = 1'b0;
  logic          step_down = 1'b0;
  logic          button = 1'b1;
  logic [1:0]    sel;
  logic          editing;
  logic [CH*W-1:0] values;
  logic          changed;

  twiddle_controller #(
    .CHANNELS(CH), .WIDTH(W), .LONG_CYCLES(LONG), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_up(step_up), .step_down(step_down), .button(button),
    .sel(sel), .editing(editing), .values(values), .changed(changed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_chg = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: low_run counts low cycles of the current hold, quiet counts
  // uneventful EDIT cycles.
  int m_sel, m_low, m_quiet;
  int m_vals [CH];
  bit m_edit, m_changed, m_prev, m_fired;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel <= 0; m_edit <= 0; m_changed <= 0; m_prev <= 1; m_fired <= 0;
      m_low <= 0; m_quiet <= 0;
      for (int i = 0; i < CH; i++) m_vals[i] <= 0;
    end else begin : model_step
      int nv [CH];
      int ns, nlow, nq;
      bit ne, nf, pressed, released, step, chg;
      nv = m_vals; ns = m_sel; ne = m_edit; nf = m_fired; nlow = m_low; nq = m_quiet;
      pressed  = m_prev && !button;
      released = !m_prev && button;
      step     = button && (step_up != step_down);
      if (!button) nlow = pressed ? 1 : ((m_low > LONG) ? m_low : m_low + 1);
      if (!button && !m_fired && nlow == LONG) begin
        nf = 1;
        if (m_edit) nv[m_sel] = 0;
        else for (int i = 0; i < CH; i++) nv[i] = 0;
      end
      if (released) begin
        if (m_fired) nf = 0;
        else ne = !m_edit;
      end
      if (step) begin
        if (!m_edit) ns = (m_sel + (step_up ? 1 : CH - 1)) % CH;
        else if (step_up) nv[m_sel] = (m_vals[m_sel] < VMAX) ? m_vals[m_sel] + 1 : VMAX;
        else nv[m_sel] = (m_vals[m_sel] > 0) ? m_vals[m_sel] - 1 : 0;
      end
      if (!m_edit || !button || released || step) begin
        nq = 0;
      end else begin
        nq = m_quiet + 1;
        if (nq == IDLE) begin
          nq = 0;
          ne = 0;
        end
      end
      chg = 0;
      for (int i = 0; i < CH; i++) if (nv[i] != m_vals[i]) chg = 1;
      m_vals <= nv; m_sel <= ns; m_edit <= ne; m_fired <= nf; m_low <= nlow;
      m_quiet <= nq; m_changed <= chg; m_prev <= button;
    end
  end

  // Counts changed pulses visible after the previous edge.
  always @(posedge clk) if (changed === 1'b1) n_chg++;

  always @(negedge clk) begin
    if (chk_en) begin
      check("sel", 64'(sel), 64'(m_sel));
      check("editing", 64'(editing), 64'(m_edit));
      check("changed", 64'(changed), 64'(m_changed));
      for (int i = 0; i < CH; i++)
        check($sformatf("val%0d", i), 64'(values[i*W +: W]), 64'(m_vals[i]));
    end
  end

  task automatic cyc(input bit up, input bit dn, input bit btn);
    step_up = up; step_down = dn; button = btn;
    @(negedge clk);
  endtask

  int base, kind, len;
  bit d;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_sel", 64'(sel), 0);
    check("rst_editing", 64'(editing), 0);
    check("rst_values", 64'(values), 0);
    check("rst_changed", 64'(changed), 0);

    // SELECT stepping with wrap
    repeat (5) begin cyc(1, 0, 1); cyc(0, 0, 1); end
    check("t1_sel_up", 64'(sel), 1);
    repeat (2) begin cyc(0, 1, 1); cyc(0, 0, 1); end
    check("t1_sel_dn", 64'(sel), 3);

    // Short press enters EDIT, three increments
    repeat (3) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("t2_editing", 64'(editing), 1);
    base = n_chg;
    repeat (3) cyc(1, 0, 1);
    cyc(0, 0, 1);
    check("t2_val", 64'(values[3*W +: W]), 3);
    check("t2_pulses", 64'(n_chg - base), 3);

    // Saturation at the top
    repeat (251) cyc(1, 0, 1);
    cyc(0, 0, 1);
    check("t3_val254", 64'(values[3*W +: W]), 254);
    base = n_chg;
    repeat (3) cyc(1, 0, 1);
    cyc(0, 0, 1);
    check("t3_val255", 64'(values[3*W +: W]), 255);
    check("t3_pulses", 64'(n_chg - base), 1);

    // Long press clears the selected channel on hold cycle 8
    repeat (7) cyc(0, 0, 0);
    check("t4_before", 64'(values[3*W +: W]), 255);
    cyc(0, 0, 0);
    check("t4_cleared", 64'(values[3*W +: W]), 0);
    check("t4_changed", 64'(changed), 1);
    repeat (4) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("t4_editing", 64'(editing), 1);
    cyc(0, 1, 1);
    check("t3_floor", 64'(values[3*W +: W]), 0);
    check("t3_nochg", 64'(changed), 0);

    // Idle timeout restarted by a step at cycle 20
    repeat (19) cyc(0, 0, 1);
    cyc(1, 0, 1);
    repeat (31) cyc(0, 0, 1);
    check("t5_still_edit", 64'(editing), 1);
    cyc(0, 0, 1);
    check("t5_timeout", 64'(editing), 0);

    // Ignored steps, then reset mid-hold
    cyc(1, 1, 1);
    check("t6_both", 64'(sel), 3);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("t6_held_sel", 64'(sel), 3);
    check("t6_held_val", 64'(values[3*W +: W]), 1);
    #2 rst_n = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    #2 rst_n = 1'b1;
    cyc(0, 0, 1);
    check("t6_sel", 64'(sel), 0);
    check("t6_editing", 64'(editing), 0);
    check("t6_values", 64'(values), 0);
    check("t6_changed", 64'(changed), 0);
    cyc(0, 0, 1);
    check("t6_no_release", 64'(editing), 0);

    // Randomized traffic
    for (int s = 0; s < 260; s++) begin
      kind = $urandom_range(0, 19);
      if (kind < 7) begin
        repeat ($urandom_range(1, 8)) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1);
      end else if (kind == 7) begin
        d = ($urandom_range(0, 1) == 1);
        repeat (260) cyc(d, !d, 1);
      end else if (kind < 14) begin
        len = $urandom_range(1, 14);
        repeat (len) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
        cyc(0, 0, 1);
      end else if (kind < 19) begin
        repeat ($urandom_range(1, 45)) cyc(0, 0, 1);
      end else begin
        #2 rst_n = 1'b0;
        cyc(0, 0, $urandom_range(0, 1) == 1);
        #2 rst_n = 1'b1;
        cyc(0, 0, $urandom_range(0, 1) == 1);
      end
    end
    cyc(0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
